// File: rtl/uart_rx_frame_check_if.sv
// Sampler/config-side and RX-FIFO-side signals of the UART RX frame checker.
// Counter signals exist only when ERR_COUNT_EN is defined.
interface uart_rx_frame_check_if #(
  parameter int DATAWIDTH = 8
`ifdef ERR_COUNT_EN
  , parameter int CNTWIDTH = 8
`endif
);
  localparam int LENW = $clog2(DATAWIDTH + 1);

  logic                 start_det;
  logic                 bit_strobe;
  logic                 ser_in;
  logic [LENW-1:0]      data_len;
  logic                 parity_en;
  logic                 parity_type;
  logic                 two_stop;
  logic [DATAWIDTH-1:0] rx_dat;
  logic                 rx_vld;
  logic                 parity_err;
  logic                 stop_err;
  logic                 busy;
`ifdef ERR_COUNT_EN
  logic                 err_clr;
  logic [CNTWIDTH-1:0]  par_err_cnt;
  logic [CNTWIDTH-1:0]  stop_err_cnt;
`endif

  modport master (
    output start_det, bit_strobe, ser_in, data_len, parity_en, parity_type, two_stop,
    input  rx_dat, rx_vld, parity_err, stop_err, busy
`ifdef ERR_COUNT_EN
    , output err_clr
    , input  par_err_cnt, stop_err_cnt
`endif
  );

  modport slave (
    input  start_det, bit_strobe, ser_in, data_len, parity_en, parity_type, two_stop,
    output rx_dat, rx_vld, parity_err, stop_err, busy
`ifdef ERR_COUNT_EN
    , input  err_clr
    , output par_err_cnt, stop_err_cnt
`endif
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: LSB-first data, optional parity, 1/2 stop bits; ERR_COUNT_EN adds saturating error counters.
// rx_vld is high the cycle after the edge consuming the last stop strobe; strobe-paced, no backpressure accepted.
module uart_rx_frame_check #(
  parameter int DATAWIDTH = 8
`ifdef ERR_COUNT_EN
  , parameter int CNTWIDTH = 8
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  uart_rx_frame_check_if.slave  rx
);
  localparam int LENW = $clog2(DATAWIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [LENW-1:0]      len_q, len_d;
  logic [LENW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 second_q, second_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 xor_q, xor_d;
  logic                 par_acc_q, par_acc_d;
  logic                 stop_acc_q, stop_acc_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;
  logic [LENW-1:0]      eff_len;

  assign eff_len = (rx.data_len == '0 || rx.data_len > LENW'(DATAWIDTH))
                 ? LENW'(DATAWIDTH) : rx.data_len;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      second_q   <= 1'b0;
      shift_q    <= '0;
      xor_q      <= 1'b0;
      par_acc_q  <= 1'b0;
      stop_acc_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      second_q   <= second_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      par_acc_q  <= par_acc_d;
      stop_acc_q <= stop_acc_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    second_d   = second_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    par_acc_d  = par_acc_q;
    stop_acc_d = stop_acc_q;
    data_d     = data_q;
    perr_d     = perr_q;
    serr_d     = serr_q;

    case (state_q)
      // DONE is the valid cycle; a start there chains straight into the next frame.
      S_IDLE, S_DONE: begin
        if (rx.start_det) begin
          state_d    = S_DATA;
          len_d      = eff_len;
          par_en_d   = rx.parity_en;
          par_odd_d  = rx.parity_type;
          two_stop_d = rx.two_stop;
          bit_cnt_d  = '0;
          second_d   = 1'b0;
          shift_d    = '0;
          xor_d      = 1'b0;
          par_acc_d  = 1'b0;
          stop_acc_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx.bit_strobe) begin
          for (int i = 0; i < DATAWIDTH; i++) begin
            if (bit_cnt_q == LENW'(i)) shift_d[i] = rx.ser_in;
          end
          xor_d     = xor_q ^ rx.ser_in;
          bit_cnt_d = bit_cnt_q + LENW'(1);
          if (bit_cnt_d == len_q) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx.bit_strobe) begin
          par_acc_d = xor_q ^ rx.ser_in ^ par_odd_q;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (rx.bit_strobe) begin
          stop_acc_d = stop_acc_q | ~rx.ser_in;
          if (two_stop_q && !second_q) begin
            second_d = 1'b1;
          end else begin
            state_d = S_DONE;
            data_d  = shift_q;
            perr_d  = par_acc_q;
            serr_d  = stop_acc_q | ~rx.ser_in;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx.rx_dat     = data_q;
  assign rx.rx_vld     = (state_q == S_DONE);
  assign rx.parity_err = perr_q;
  assign rx.stop_err   = serr_q;
  assign rx.busy       = (state_q != S_IDLE);

`ifdef ERR_COUNT_EN
  logic [CNTWIDTH-1:0] par_cnt_q, par_cnt_d;
  logic [CNTWIDTH-1:0] stop_cnt_q, stop_cnt_d;

  always_comb begin
    par_cnt_d  = par_cnt_q;
    stop_cnt_d = stop_cnt_q;
    if (rx.err_clr) begin
      par_cnt_d  = '0;
      stop_cnt_d = '0;
    end else if (state_q == S_DONE) begin
      if (perr_q && par_cnt_q != '1)  par_cnt_d  = par_cnt_q + CNTWIDTH'(1);
      if (serr_q && stop_cnt_q != '1) stop_cnt_d = stop_cnt_q + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      par_cnt_q  <= par_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign rx.par_err_cnt  = par_cnt_q;
  assign rx.stop_err_cnt = stop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: directed frame table, corner sequences, and randomized frames vs a reference model.
module tb_uart_rx_frame_check;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef ERR_COUNT_EN
  uart_rx_frame_check_if #(.DATAWIDTH(DW), .CNTWIDTH(2)) bus ();
  uart_rx_frame_check #(.DATAWIDTH(DW), .CNTWIDTH(2)) dut (.clk_i(clk), .rst_ni(rst_n), .rx(bus.slave));
`else
  uart_rx_frame_check_if #(.DATAWIDTH(DW)) bus ();
  uart_rx_frame_check #(.DATAWIDTH(DW)) dut (.clk_i(clk), .rst_ni(rst_n), .rx(bus.slave));
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       pen, ptype, two, pbit, s1, s2;
    logic [7:0] exp_d;
    logic       exp_p, exp_s;
  } vec_t;

  typedef struct {
    int         nvld;
    logic       end_vld;
    logic [7:0] d;
    logic       p, s;
    logic       busy_ok;
    logic       busy_after;
  } res_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [3:0] l);
    return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
  endfunction

  // Reference: what the spec says the frame should decode to, from the line bits alone.
  function automatic void model(input vec_t v, output logic [7:0] d, output logic p, output logic s);
    int n;
    n = eff_len(v.len);
    d = 8'(int'(v.data) & ((1 << n) - 1));
    p = v.pen ? 1'(($countones(d) + int'(v.pbit) + int'(v.ptype)) % 2) : 1'b0;
    s = !v.s1 || (v.two && !v.s2);
  endfunction

  task automatic sample(inout res_t r);
    if (!bus.busy) r.busy_ok = 1'b0;
    if (bus.rx_vld) begin
      r.nvld++;
      r.d = bus.rx_dat;
      r.p = bus.parity_err;
      r.s = bus.stop_err;
    end
  endtask

  task automatic scramble();
    bus.start_det   = ($urandom_range(0, 3) == 0);
    bus.data_len    = 4'($urandom_range(0, 15));
    bus.parity_en   = 1'($urandom_range(0, 1));
    bus.parity_type = 1'($urandom_range(0, 1));
    bus.two_stop    = 1'($urandom_range(0, 1));
    bus.ser_in      = 1'($urandom_range(0, 1));
  endtask

  // Drives one frame starting with the start_det cycle; returns at the cycle valid is expected.
  task automatic run_frame(input vec_t v, input bit rnd, input bit tail, output res_t r);
    logic q[$];
    int   n;
    n = eff_len(v.len);
    for (int i = 0; i < n; i++) q.push_back(v.data[i]);
    if (v.pen) q.push_back(v.pbit);
    q.push_back(v.s1);
    if (v.two) q.push_back(v.s2);
    r.nvld = 0; r.end_vld = 1'b0; r.d = '0; r.p = 1'b0; r.s = 1'b0;
    r.busy_ok = 1'b1; r.busy_after = 1'b0;

    bus.start_det   = 1'b1;
    bus.data_len    = v.len;
    bus.parity_en   = v.pen;
    bus.parity_type = v.ptype;
    bus.two_stop    = v.two;
    bus.bit_strobe  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.ser_in      = 1'($urandom_range(0, 1));
    tick();
    sample(r);
    bus.start_det  = 1'b0;
    bus.bit_strobe = 1'b0;

    foreach (q[i]) begin
      int gap;
      gap = rnd ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gap; g++) begin
        scramble();
        tick();
        sample(r);
      end
      bus.start_det  = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.bit_strobe = 1'b1;
      bus.ser_in     = q[i];
      tick();
      sample(r);
      bus.bit_strobe = 1'b0;
      bus.start_det  = 1'b0;
    end
    r.end_vld = bus.rx_vld;

    if (tail) begin
      tick();
      r.busy_after = bus.busy;
      if (bus.rx_vld) r.nvld++;
      repeat (2) begin
        tick();
        if (bus.rx_vld) r.nvld++;
      end
    end
  endtask

  vec_t vt[13];
  vec_t v;
  res_t r, r2;
  logic [7:0] md;
  logic mp, ms;
  int nv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           data   len   pen   ptype two   pbit  s1    s2    exp_d  exp_p exp_s
    vt[0]  = '{8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1]  = '{8'h03, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vt[2]  = '{8'h03, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vt[3]  = '{8'h1F, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
    vt[4]  = '{8'h1F, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0};
    vt[5]  = '{8'hC3, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1};
    vt[6]  = '{8'h5A, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[7]  = '{8'h81, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vt[8]  = '{8'hFF, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[9]  = '{8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1};
    vt[10] = '{8'h2B, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2B, 1'b1, 1'b1};
    vt[11] = '{8'h00, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[12] = '{8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};

    rst_n           = 1'b0;
    bus.start_det   = 1'b0;
    bus.bit_strobe  = 1'b0;
    bus.ser_in      = 1'b1;
    bus.data_len    = 4'd8;
    bus.parity_en   = 1'b0;
    bus.parity_type = 1'b0;
    bus.two_stop    = 1'b0;
`ifdef ERR_COUNT_EN
    bus.err_clr     = 1'b0;
`endif
    repeat (3) tick();
    check("reset_dat", bus.rx_dat, 8'h00);
    check("reset_vld", bus.rx_vld, 1'b0);
    check("reset_perr", bus.parity_err, 1'b0);
    check("reset_serr", bus.stop_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
`ifdef ERR_COUNT_EN
    check("reset_pcnt", bus.par_err_cnt, 2'd0);
    check("reset_scnt", bus.stop_err_cnt, 2'd0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_frame(vt[i], 1'b0, 1'b1, r);
      check($sformatf("vec%0d_nvld", i), r.nvld, 1);
      check($sformatf("vec%0d_vld_timing", i), r.end_vld, 1'b1);
      check($sformatf("vec%0d_dat", i), r.d, vt[i].exp_d);
      check($sformatf("vec%0d_perr", i), r.p, vt[i].exp_p);
      check($sformatf("vec%0d_serr", i), r.s, vt[i].exp_s);
    end

    // Reset after four data strobes: the partial frame must never produce a valid.
    bus.start_det = 1'b1;
    bus.data_len  = 4'd8;
    bus.parity_en = 1'b0;
    bus.two_stop  = 1'b0;
    tick();
    bus.start_det = 1'b0;
    repeat (4) begin
      bus.bit_strobe = 1'b1;
      bus.ser_in     = 1'b1;
      tick();
    end
    bus.bit_strobe = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_vld", bus.rx_vld, 1'b0);
    tick();
    rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      bus.bit_strobe = 1'b1;
      bus.ser_in     = 1'b1;
      tick();
      if (bus.rx_vld) nv++;
    end
    bus.bit_strobe = 1'b0;
    check("midrst_no_vld", nv, 0);
    v = '{8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    run_frame(v, 1'b0, 1'b1, r);
    check("postrst_nvld", r.nvld, 1);
    check("postrst_dat", r.d, 8'h3C);

    // Back-to-back: the second start lands in the first frame's valid cycle.
    v = '{8'h11, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
    run_frame(v, 1'b0, 1'b0, r);
    v = '{8'hE7, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE7, 1'b0, 1'b0};
    run_frame(v, 1'b0, 1'b1, r2);
    check("b2b_a_nvld", r.nvld, 1);
    check("b2b_a_dat", r.d, 8'h11);
    check("b2b_a_busy", r.busy_ok, 1'b1);
    check("b2b_b_nvld", r2.nvld, 1);
    check("b2b_b_dat", r2.d, 8'hE7);
    check("b2b_b_busy", r2.busy_ok, 1'b1);
    check("b2b_b_idle", r2.busy_after, 1'b0);

    for (int i = 0; i < 60; i++) begin
      v.data  = 8'($urandom);
      v.len   = 4'($urandom_range(0, 15));
      v.pen   = 1'($urandom_range(0, 1));
      v.ptype = 1'($urandom_range(0, 1));
      v.two   = 1'($urandom_range(0, 1));
      v.pbit  = 1'($urandom_range(0, 1));
      v.s1    = ($urandom_range(0, 3) != 0);
      v.s2    = ($urandom_range(0, 3) != 0);
      model(v, md, mp, ms);
      run_frame(v, 1'b1, 1'b1, r);
      check($sformatf("rnd%0d_nvld", i), r.nvld, 1);
      check($sformatf("rnd%0d_vld_timing", i), r.end_vld, 1'b1);
      check($sformatf("rnd%0d_dat", i), r.d, md);
      check($sformatf("rnd%0d_perr", i), r.p, mp);
      check($sformatf("rnd%0d_serr", i), r.s, ms);
      check($sformatf("rnd%0d_busy", i), r.busy_ok, 1'b1);
      check($sformatf("rnd%0d_idle", i), r.busy_after, 1'b0);
    end

`ifdef ERR_COUNT_EN
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("cnt_clr0", bus.par_err_cnt, 2'd0);
    v = '{8'h03, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    repeat (5) run_frame(v, 1'b0, 1'b1, r);
    check("cnt_par_sat", bus.par_err_cnt, 2'd3);
    check("cnt_stop_zero", bus.stop_err_cnt, 2'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("cnt_par_clr", bus.par_err_cnt, 2'd0);
    run_frame(v, 1'b0, 1'b0, r);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("cnt_clr_wins", bus.par_err_cnt, 2'd0);
    v = '{8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    run_frame(v, 1'b0, 1'b1, r);
    check("cnt_stop_one", bus.stop_err_cnt, 2'd1);
    check("cnt_par_still0", bus.par_err_cnt, 2'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
